// File: rtl/jam_cost_scheduler_if.sv
// Bundle between the permutation generator / cost memory and the cost scheduler.
// master = scheduler side, slave = generator, memory and result consumer side.
interface jam_cost_scheduler_if #(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
);
  // Handshake: a permutation transfers on any cycle where perm_valid && perm_ready
  // are both high; the source holds perm_in stable while perm_valid && !perm_ready.
  logic                 perm_valid;
  logic [N*IDX_W-1:0]   perm_in;
  logic                 perm_ready;
  logic                 cost_req;
  logic [IDX_W-1:0]     W;
  logic [IDX_W-1:0]     J;
  logic [COST_W-1:0]    Cost;
  logic                 sum_valid;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     min_cost;
  logic [CNT_W-1:0]     match_count;
  logic                 done;

  modport master (
    input  perm_valid, perm_in, Cost,
    output perm_ready, cost_req, W, J, sum_valid, sum, min_cost, match_count, done
  );

  modport slave (
    output perm_valid, perm_in, Cost,
    input  perm_ready, cost_req, W, J, sum_valid, sum, min_cost, match_count, done
  );
endinterface

// File: rtl/jam_cost_scheduler.sv
// Walks the cost memory for one permutation at a time, accumulates its total cost,
// and tracks the running minimum and how many permutations reached it.
module jam_cost_scheduler #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int COST_W   = 7,
  parameter int SUM_W    = 10,
  parameter int NUM_PERM = 40320,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  jam_cost_scheduler_if.master  io_bus,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [N*IDX_W-1:0]   r_perm;
  logic [IDX_W-1:0]     r_idx;
  logic [SUM_W-1:0]     r_acc;
  logic [SUM_W-1:0]     r_sum;
  logic [SUM_W-1:0]     r_min;
  logic [CNT_W-1:0]     r_match;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_cost_req;
  logic [IDX_W-1:0]     r_w;
  logic [IDX_W-1:0]     r_j;
  logic                 r_sum_valid;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [IDX_W-1:0]     w_j_nxt;
  logic [SUM_W-1:0]     w_cost_ext;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_hit_end;

  assign w_accept   = (r_state == S_IDLE) && io_bus.perm_valid;
  assign w_last     = (r_idx == IDX_W'(N - 1));
  assign w_idx_nxt  = r_idx + 1'b1;
  assign w_j_nxt    = r_perm[w_idx_nxt*IDX_W +: IDX_W];
  assign w_cost_ext = {{(SUM_W - COST_W){1'b0}}, io_bus.Cost};
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_hit_end  = (w_cnt_nxt == CNT_W'(NUM_PERM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_FETCH;
      S_FETCH:  if (w_last) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_UPDATE;
      S_UPDATE: w_next = w_hit_end ? S_DONE : S_IDLE;
      S_DONE:   w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Memory data lags the address by one cycle, so FETCH at idx adds the entry for
  // idx-1 and DRAIN picks up the final entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perm      <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_min       <= '1;
      r_match     <= '0;
      r_cnt       <= '0;
      r_cost_req  <= 1'b0;
      r_w         <= '0;
      r_j         <= '0;
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_perm     <= io_bus.perm_in;
            r_acc      <= '0;
            r_idx      <= '0;
            r_w        <= '0;
            r_j        <= io_bus.perm_in[IDX_W-1:0];
            r_cost_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (r_idx != '0) r_acc <= r_acc + w_cost_ext;
          if (!w_last) begin
            r_idx <= w_idx_nxt;
            r_w   <= w_idx_nxt;
            r_j   <= w_j_nxt;
          end else begin
            r_cost_req <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_acc       <= r_acc + w_cost_ext;
          r_sum       <= r_acc + w_cost_ext;
          r_sum_valid <= 1'b1;
        end
        S_UPDATE: begin
          if (r_sum < r_min) begin
            r_min   <= r_sum;
            r_match <= CNT_W'(1);
          end else if (r_sum == r_min) begin
            r_match <= r_match + 1'b1;
          end
          r_cnt <= w_cnt_nxt;
          if (w_hit_end) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.perm_ready  = (r_state == S_IDLE);
  assign io_bus.cost_req    = r_cost_req;
  assign io_bus.W           = r_w;
  assign io_bus.J           = r_j;
  assign io_bus.sum_valid   = r_sum_valid;
  assign io_bus.sum         = r_sum;
  assign io_bus.min_cost    = r_min;
  assign io_bus.match_count = r_match;
  assign io_bus.done        = r_done;
  assign o_dbg_state        = r_state;

endmodule
